// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve
// Brief   : EX-stage branch/jump resolution with fetch redirect handshake,
//           wrong-path flushes and saturating branch perf counters.
// Rev     : 1.0  initial release
// ============================================================================
module branch_resolve #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ex_valid,
    input  logic             i_is_branch,
    input  logic             i_is_jal,
    input  logic             i_is_jalr,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_target,
    input  logic             i_br_eq,
    input  logic             i_br_lt,
    output logic             o_br_un,
    output logic             o_redirect_valid,
    output logic [XLEN-1:0]  o_redirect_pc,
    input  logic             i_redirect_ready,
    output logic             o_flush_if_id,
    output logic             o_flush_id_ex,
    output logic             o_misalign,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [XLEN-1:0]   r_redirect_pc;
    logic              r_misalign;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic              w_sel_jalr;
    logic              w_sel_jal;
    logic              w_sel_br;
    logic              w_accepted;
    logic              w_br_taken;
    logic              w_taken;
    logic              w_illegal;
    logic [XLEN-1:0]   w_eff_target;
    logic              w_misalign;
    logic              w_go_redirect;
    logic              w_count_br;

    // Comparator signedness comes straight from funct3 so its flags are valid this cycle.
    assign o_br_un = i_funct3[1];

    // Overlapping type flags resolve as jalr > jal > branch.
    assign w_sel_jalr = i_is_jalr;
    assign w_sel_jal  = i_is_jal & ~i_is_jalr;
    assign w_sel_br   = i_is_branch & ~i_is_jal & ~i_is_jalr;

    assign w_accepted = (r_state == IDLE) & i_ex_valid
                      & (i_is_branch | i_is_jal | i_is_jalr);

    always_comb begin
        w_br_taken = 1'b0;
        case (i_funct3)
            3'b000:  w_br_taken =  i_br_eq;
            3'b001:  w_br_taken = ~i_br_eq;
            3'b100:  w_br_taken =  i_br_lt;
            3'b101:  w_br_taken = ~i_br_lt;
            3'b110:  w_br_taken =  i_br_lt;
            3'b111:  w_br_taken = ~i_br_lt;
            default: w_br_taken = 1'b0;
        endcase
    end

    assign w_illegal    = w_sel_br & (i_funct3[2:1] == 2'b01);
    assign w_taken      = w_sel_jalr | w_sel_jal | (w_sel_br & w_br_taken);
    assign w_eff_target = w_sel_jalr ? {i_target[XLEN-1:1], 1'b0} : i_target;
    assign w_misalign   = w_taken & w_eff_target[1];

    assign w_go_redirect = w_accepted & w_taken & ~w_eff_target[1];
    assign w_count_br    = w_accepted & w_sel_br & ~w_illegal;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_go_redirect)    w_state_nxt = REDIRECT;
            REDIRECT: if (i_redirect_ready) w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_redirect_pc <= '0;
            r_misalign    <= 1'b0;
            r_illegal     <= 1'b0;
            r_branch_cnt  <= '0;
            r_taken_cnt   <= '0;
        end else begin
            r_misalign <= w_accepted & w_misalign;
            r_illegal  <= w_accepted & w_illegal;
            // Capture only on entry so the target stays frozen for the whole request.
            if (w_go_redirect) begin
                r_redirect_pc <= w_eff_target;
            end
            if (w_count_br && (r_branch_cnt != {CNT_W{1'b1}})) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_count_br && w_br_taken && (r_taken_cnt != {CNT_W{1'b1}})) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
        end
    end

    assign o_redirect_valid = (r_state == REDIRECT);
    assign o_redirect_pc    = r_redirect_pc;
    assign o_flush_if_id    = (r_state == REDIRECT);
    assign o_flush_id_ex    = (r_state == REDIRECT);
    assign o_misalign       = r_misalign;
    assign o_illegal        = r_illegal;
    assign o_branch_cnt     = r_branch_cnt;
    assign o_taken_cnt      = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_resolve
// Brief   : Directed self-checking bench for branch_resolve (CNT_W 16 and 4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic [31:0] target;
    logic        br_eq;
    logic        br_lt;
    logic        redirect_ready;

    logic        br_un,  br_un4;
    logic        rd_valid, rd_valid4;
    logic [31:0] rd_pc, rd_pc4;
    logic        fl_ifid, fl_ifid4;
    logic        fl_idex, fl_idex4;
    logic        misalign, misalign4;
    logic        illegal, illegal4;
    logic [15:0] branch_cnt, taken_cnt;
    logic [3:0]  branch_cnt4, taken_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve #(.XLEN(32), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid),
        .i_is_branch(is_branch), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
        .i_funct3(funct3), .i_target(target), .i_br_eq(br_eq), .i_br_lt(br_lt),
        .o_br_un(br_un), .o_redirect_valid(rd_valid), .o_redirect_pc(rd_pc),
        .i_redirect_ready(redirect_ready), .o_flush_if_id(fl_ifid),
        .o_flush_id_ex(fl_idex), .o_misalign(misalign), .o_illegal(illegal),
        .o_branch_cnt(branch_cnt), .o_taken_cnt(taken_cnt)
    );

    branch_resolve #(.XLEN(32), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid),
        .i_is_branch(is_branch), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
        .i_funct3(funct3), .i_target(target), .i_br_eq(br_eq), .i_br_lt(br_lt),
        .o_br_un(br_un4), .o_redirect_valid(rd_valid4), .o_redirect_pc(rd_pc4),
        .i_redirect_ready(redirect_ready), .o_flush_if_id(fl_ifid4),
        .o_flush_id_ex(fl_idex4), .o_misalign(misalign4), .o_illegal(illegal4),
        .o_branch_cnt(branch_cnt4), .o_taken_cnt(taken_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ex_valid  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        funct3    = 3'b000;
        target    = 32'h0;
        br_eq     = 1'b0;
        br_lt     = 1'b0;
    endtask

    task automatic present(input logic br, input logic jal, input logic jalr,
                           input logic [2:0] f3, input logic [31:0] tgt,
                           input logic eq, input logic lt);
        ex_valid  = 1'b1;
        is_branch = br;
        is_jal    = jal;
        is_jalr   = jalr;
        funct3    = f3;
        target    = tgt;
        br_eq     = eq;
        br_lt     = lt;
    endtask

    // Called #1 after a rising edge; reset pulse stays clear of the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check_redirect(input string tag, input logic v, input logic [31:0] pc);
        check({tag, "_valid"}, {31'b0, rd_valid}, {31'b0, v});
        check({tag, "_pc"}, rd_pc, pc);
        check({tag, "_flush_ifid"}, {31'b0, fl_ifid}, {31'b0, v});
        check({tag, "_flush_idex"}, {31'b0, fl_idex}, {31'b0, v});
    endtask

    initial begin
        clear_in();
        redirect_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        check_redirect("rst", 1'b0, 32'h0);
        check("rst_bcnt", {16'b0, branch_cnt}, 32'd0);
        check("rst_tcnt", {16'b0, taken_cnt}, 32'd0);
        check("rst_mis", {31'b0, misalign}, 32'd0);
        check("rst_ill", {31'b0, illegal}, 32'd0);
        rst_n = 1'b1;
        step();

        // BEQ taken
        present(1, 0, 0, 3'b000, 32'h100, 1, 0);
        #1 check("beq_brun", {31'b0, br_un}, 32'd0);
        step();
        clear_in();
        check_redirect("beq", 1'b1, 32'h100);
        check("beq_bcnt", {16'b0, branch_cnt}, 32'd1);
        check("beq_tcnt", {16'b0, taken_cnt}, 32'd1);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        check_redirect("beq_done", 1'b0, 32'h100);

        // BLTU not taken
        do_reset();
        present(1, 0, 0, 3'b110, 32'h200, 0, 0);
        #1 check("bltu_brun", {31'b0, br_un}, 32'd1);
        step();
        clear_in();
        check("bltu_valid", {31'b0, rd_valid}, 32'd0);
        check("bltu_bcnt", {16'b0, branch_cnt}, 32'd1);
        check("bltu_tcnt", {16'b0, taken_cnt}, 32'd0);

        // BGE taken (lt=0), BNE not taken, BLT taken stacked behind handshakes
        do_reset();
        present(1, 0, 0, 3'b101, 32'h240, 0, 0);
        #1 check("bge_brun", {31'b0, br_un}, 32'd0);
        step();
        clear_in();
        check_redirect("bge", 1'b1, 32'h240);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        present(1, 0, 0, 3'b001, 32'h280, 1, 0);
        step();
        check("bne_nt_valid", {31'b0, rd_valid}, 32'd0);
        present(1, 0, 0, 3'b100, 32'h2c0, 0, 1);
        step();
        clear_in();
        check_redirect("blt", 1'b1, 32'h2c0);
        check("blt_bcnt", {16'b0, branch_cnt}, 32'd3);
        check("blt_tcnt", {16'b0, taken_cnt}, 32'd2);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;

        // JALR clears bit0; misaligned JALR pulses misalign only
        do_reset();
        present(0, 0, 1, 3'b000, 32'h1001, 0, 0);
        step();
        clear_in();
        check_redirect("jalr", 1'b1, 32'h1000);
        check("jalr_bcnt", {16'b0, branch_cnt}, 32'd0);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        present(0, 0, 1, 3'b000, 32'h1006, 0, 0);
        step();
        clear_in();
        check("jalr_mis", {31'b0, misalign}, 32'd1);
        check("jalr_mis_valid", {31'b0, rd_valid}, 32'd0);
        step();
        check("jalr_mis_pulse", {31'b0, misalign}, 32'd0);

        // Illegal funct3 010
        present(1, 0, 0, 3'b010, 32'h300, 1, 1);
        step();
        clear_in();
        check("ill_pulse", {31'b0, illegal}, 32'd1);
        check("ill_valid", {31'b0, rd_valid}, 32'd0);
        check("ill_bcnt", {16'b0, branch_cnt}, 32'd0);
        step();
        check("ill_pulse_end", {31'b0, illegal}, 32'd0);

        // Priority: jal beats branch with illegal funct3
        present(1, 1, 0, 3'b011, 32'h500, 0, 0);
        step();
        clear_in();
        check_redirect("prio", 1'b1, 32'h500);
        check("prio_ill", {31'b0, illegal}, 32'd0);
        check("prio_bcnt", {16'b0, branch_cnt}, 32'd0);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;

        // Ready held low 3 cycles; wrong-path BEQ ignored through the handshake
        do_reset();
        present(1, 0, 0, 3'b000, 32'h600, 1, 0);
        step();
        present(1, 0, 0, 3'b000, 32'h700, 1, 0);
        for (int i = 0; i < 3; i++) begin
            check_redirect($sformatf("hold%0d", i), 1'b1, 32'h600);
            step();
        end
        redirect_ready = 1'b1;
        check_redirect("hold3", 1'b1, 32'h600);
        step();
        redirect_ready = 1'b0;
        clear_in();
        check("hold_done_valid", {31'b0, rd_valid}, 32'd0);
        check("hold_bcnt", {16'b0, branch_cnt}, 32'd1);
        check("hold_tcnt", {16'b0, taken_cnt}, 32'd1);

        // Saturation: 20 taken BNEs to a misaligned target (no redirects)
        do_reset();
        present(1, 0, 0, 3'b001, 32'h102, 0, 0);
        repeat (20) step();
        clear_in();
        check("sat4_bcnt", {28'b0, branch_cnt4}, 32'd15);
        check("sat4_tcnt", {28'b0, taken_cnt4}, 32'd15);
        check("sat16_bcnt", {16'b0, branch_cnt}, 32'd20);
        check("sat16_tcnt", {16'b0, taken_cnt}, 32'd20);
        check("sat_valid", {31'b0, rd_valid4}, 32'd0);

        // Async reset in the middle of a redirect
        present(1, 0, 0, 3'b001, 32'h800, 0, 0);
        step();
        clear_in();
        check("mid_valid_pre", {31'b0, rd_valid4}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_redirect("mid_rst", 1'b0, 32'h0);
        check("mid_rst_valid4", {31'b0, rd_valid4}, 32'd0);
        check("mid_rst_bcnt4", {28'b0, branch_cnt4}, 32'd0);
        check("mid_rst_tcnt4", {28'b0, taken_cnt4}, 32'd0);
        check("mid_rst_bcnt", {16'b0, branch_cnt}, 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_valid", {31'b0, rd_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
